// File: rtl/irq_timer_gen_pkg.sv
// Shared definitions for the machine-level interrupt source block:
// register map, mie/mip bit positions, FSM encoding and cause selection.
package irq_timer_gen_pkg;

  localparam logic [4:0] MSIP_OFS        = 5'h00;
  localparam logic [4:0] MTIMECMP_LO_OFS = 5'h08;
  localparam logic [4:0] MTIMECMP_HI_OFS = 5'h0C;
  localparam logic [4:0] MTIME_LO_OFS    = 5'h10;
  localparam logic [4:0] MTIME_HI_OFS    = 5'h14;

  localparam int unsigned MIP_MSI     = 11;
  localparam int unsigned MIP_MTI     = 7;
  localparam int unsigned MIP_MEI     = 3;
  localparam int unsigned MSTATUS_MIE = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } irq_state_e;

  typedef struct packed {
    logic me;
    logic ms;
    logic mt;
  } irq_cause_t;

  // Fixed priority me > ms > mt, result is one-hot or all-zero.
  function automatic irq_cause_t prio_cause(input logic en_me, input logic en_ms,
                                            input logic en_mt);
    irq_cause_t c;
    c.me = en_me;
    c.ms = en_ms & ~en_me;
    c.mt = en_mt & ~en_me & ~en_ms;
    return c;
  endfunction

endpackage

// File: rtl/irq_timer_gen_mtime_counter.sv
// Prescaled 64-bit mtime counter; a bus write to either half replaces the
// increment for that cycle and leaves the other half untouched.
module irq_timer_gen_mtime_counter
  import irq_timer_gen_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_mtime
);

  logic [15:0] r_presc;
  logic [15:0] w_presc_d;
  logic [63:0] r_mtime;
  logic [63:0] w_mtime_d;
  logic        w_tick;

  assign w_tick    = (r_presc == 16'(PRESCALE - 1));
  assign w_presc_d = w_tick ? 16'd0 : r_presc + 16'd1;

  always_comb begin
    w_mtime_d = r_mtime;
    if (i_wr_lo) begin
      w_mtime_d[31:0] = i_wdata;
    end else if (i_wr_hi) begin
      w_mtime_d[63:32] = i_wdata;
    end else if (w_tick) begin
      w_mtime_d = r_mtime + 64'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= 16'd0;
      r_mtime <= 64'd0;
    end else begin
      r_presc <= w_presc_d;
      r_mtime <= w_mtime_d;
    end
  end

  assign o_mtime = r_mtime;

endmodule

// File: rtl/irq_timer_gen.sv
// Machine interrupt source: msip/mtime/mtimecmp registers, external line
// synchroniser, enable qualification and req/ack handshake to write-back.
module irq_timer_gen
  import irq_timer_gen_pkg::*;
#(
  parameter int unsigned PRESCALE     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        cpurst_n,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  input  logic        ext_irq,
  input  logic [31:0] mstatus,
  input  logic [31:0] mie,
  output logic        mip_msip,
  output logic        mip_mtip,
  output logic        mip_meip,
  output logic        irq_req,
  output logic        irq_ms,
  output logic        irq_mt,
  output logic        irq_me,
  input  logic        irq_ack
);

  logic        r_msip;
  logic [63:0] r_mtimecmp;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_mip_mtip;
  logic        r_mip_meip;
  logic [31:0] r_rdata;
  logic        r_rvalid;
  irq_state_e  r_state;
  logic        r_irq_req;
  irq_cause_t  r_cause;

  logic [63:0] w_mtime;
  logic [31:0] w_rdata;
  logic        w_wr_mtime_lo;
  logic        w_wr_mtime_hi;
  logic        w_en_me;
  logic        w_en_ms;
  logic        w_en_mt;
  logic        w_take;
  irq_cause_t  w_cause;
  logic        w_unused;

  assign w_wr_mtime_lo = bus_wr && (bus_addr == MTIME_LO_OFS);
  assign w_wr_mtime_hi = bus_wr && (bus_addr == MTIME_HI_OFS);

  irq_timer_gen_mtime_counter #(
    .PRESCALE (PRESCALE)
  ) u_mtime (
    .i_clk   (clk),
    .i_rst_n (cpurst_n),
    .i_wr_lo (w_wr_mtime_lo),
    .i_wr_hi (w_wr_mtime_hi),
    .i_wdata (bus_wdata),
    .o_mtime (w_mtime)
  );

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      r_msip     <= 1'b0;
      r_mtimecmp <= MTIMECMP_RST;
    end else if (bus_wr) begin
      if (bus_addr == MSIP_OFS)        r_msip             <= bus_wdata[0];
      if (bus_addr == MTIMECMP_LO_OFS) r_mtimecmp[31:0]   <= bus_wdata;
      if (bus_addr == MTIMECMP_HI_OFS) r_mtimecmp[63:32]  <= bus_wdata;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (bus_addr)
      MSIP_OFS:        w_rdata = {31'd0, r_msip};
      MTIMECMP_LO_OFS: w_rdata = r_mtimecmp[31:0];
      MTIMECMP_HI_OFS: w_rdata = r_mtimecmp[63:32];
      MTIME_LO_OFS:    w_rdata = w_mtime[31:0];
      MTIME_HI_OFS:    w_rdata = w_mtime[63:32];
      default:         w_rdata = 32'd0;
    endcase
  end

  // Reads sample pre-edge register state, so a same-cycle write returns the old value.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      r_rdata  <= 32'd0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= bus_rd;
      if (bus_rd) r_rdata <= w_rdata;
    end
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_mip_meip <= 1'b0;
      r_mip_mtip <= 1'b0;
    end else begin
      r_sync1    <= ext_irq;
      r_sync2    <= r_sync1;
      r_mip_meip <= r_sync2;
      r_mip_mtip <= (w_mtime >= r_mtimecmp);
    end
  end

  assign w_en_me = r_mip_meip & mie[MIP_MEI];
  assign w_en_ms = r_msip     & mie[MIP_MSI];
  assign w_en_mt = r_mip_mtip & mie[MIP_MTI];
  assign w_take  = mstatus[MSTATUS_MIE] & (w_en_me | w_en_ms | w_en_mt);
  assign w_cause = prio_cause(w_en_me, w_en_ms, w_en_mt);

  // The cause is latched on entry to StReq and held until the request ends.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      r_state   <= StIdle;
      r_irq_req <= 1'b0;
      r_cause   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_take) begin
            r_state   <= StReq;
            r_irq_req <= 1'b1;
            r_cause   <= w_cause;
          end
        end
        StReq: begin
          if (irq_ack) begin
            r_state   <= StHold;
            r_irq_req <= 1'b0;
            r_cause   <= '0;
          end else if (!w_take) begin
            r_state   <= StIdle;
            r_irq_req <= 1'b0;
            r_cause   <= '0;
          end
        end
        StHold: begin
          r_state <= StIdle;
        end
        default: begin
          r_state   <= StIdle;
          r_irq_req <= 1'b0;
          r_cause   <= '0;
        end
      endcase
    end
  end

  assign bus_rdata  = r_rdata;
  assign bus_rvalid = r_rvalid;
  assign mip_msip   = r_msip;
  assign mip_mtip   = r_mip_mtip;
  assign mip_meip   = r_mip_meip;
  assign irq_req    = r_irq_req;
  assign irq_me     = r_cause.me;
  assign irq_ms     = r_cause.ms;
  assign irq_mt     = r_cause.mt;

  assign w_unused = ^{mstatus[31:4], mstatus[2:0], mie[31:12], mie[10:8], mie[6:4],
                      mie[2:0]};

endmodule

// File: tb/tb_irq_timer_gen.sv
// Scoreboard bench for irq_timer_gen: randomized bus traffic against a register-level
// model, plus directed interrupt handshake sequences checked through a cause queue.
module tb_irq_timer_gen;

  localparam int unsigned P = 3;

  logic        clk;
  logic        cpurst_n;
  logic        bus_wr;
  logic        bus_rd;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        ext_irq;
  logic [31:0] mstatus;
  logic [31:0] mie;
  logic        mip_msip;
  logic        mip_mtip;
  logic        mip_meip;
  logic        irq_req;
  logic        irq_ms;
  logic        irq_mt;
  logic        irq_me;
  logic        irq_ack;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd_q[$];
  logic [2:0]  cause_q[$];
  logic        chk_en = 1'b0;
  logic        prev_req = 1'b0;

  // Reference model state (register-level behaviour only).
  int unsigned m_cycle;
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_msip;
  logic        m_mtip;

  irq_timer_gen #(
    .PRESCALE     (P),
    .MTIMECMP_RST (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk        (clk),
    .cpurst_n   (cpurst_n),
    .bus_wr     (bus_wr),
    .bus_rd     (bus_rd),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .ext_irq    (ext_irq),
    .mstatus    (mstatus),
    .mie        (mie),
    .mip_msip   (mip_msip),
    .mip_mtip   (mip_mtip),
    .mip_meip   (mip_meip),
    .irq_req    (irq_req),
    .irq_ms     (irq_ms),
    .irq_mt     (irq_mt),
    .irq_me     (irq_me),
    .irq_ack    (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      m_cycle <= 0;
      m_mtime <= 64'd0;
      m_cmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
      m_msip  <= 1'b0;
      m_mtip  <= 1'b0;
    end else begin
      m_cycle <= m_cycle + 1;
      m_mtip  <= (m_mtime >= m_cmp);
      if (bus_wr && bus_addr == 5'h00) m_msip <= bus_wdata[0];
      if (bus_wr && bus_addr == 5'h08) m_cmp <= {m_cmp[63:32], bus_wdata};
      if (bus_wr && bus_addr == 5'h0C) m_cmp <= {bus_wdata, m_cmp[31:0]};
      if (bus_wr && bus_addr == 5'h10)      m_mtime <= {m_mtime[63:32], bus_wdata};
      else if (bus_wr && bus_addr == 5'h14) m_mtime <= {bus_wdata, m_mtime[31:0]};
      else if ((m_cycle % P) == P - 1)      m_mtime <= m_mtime + 64'd1;
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'h00:   return {31'd0, m_msip};
      5'h08:   return m_cmp[31:0];
      5'h0C:   return m_cmp[63:32];
      5'h10:   return m_mtime[31:0];
      5'h14:   return m_mtime[63:32];
      default: return 32'd0;
    endcase
  endfunction

  // Read-data monitor.
  always @(negedge clk) begin
    if (bus_rvalid) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rvalid_unexpected: got rdata 0x%0h, expected no read", bus_rdata);
      end else begin
        check("bus_rdata", bus_rdata, rd_q.pop_front());
      end
    end
  end

  // Interrupt cause monitor: compare on each new request.
  always @(negedge clk) begin
    if (irq_req && !prev_req) begin
      if (cause_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL irq_unexpected: got cause %b, expected no request",
                 {irq_me, irq_ms, irq_mt});
      end else begin
        check("irq_cause", {irq_me, irq_ms, irq_mt}, cause_q.pop_front());
      end
    end
    prev_req = irq_req;
  end

  // Pending-level monitor.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mip_mtip", mip_mtip, m_mtip);
      check("mip_msip", mip_msip, m_msip);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_op(input logic wr, input logic rd, input logic [4:0] a,
                        input logic [31:0] d);
    bus_wr    = wr;
    bus_rd    = rd;
    bus_addr  = a;
    bus_wdata = d;
    if (rd) rd_q.push_back(model_read(a));
    tick();
    bus_wr = 1'b0;
    bus_rd = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus_op(1'b1, 1'b0, a, d);
  endtask

  task automatic bus_read(input logic [4:0] a);
    bus_op(1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic wait_req(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (irq_req) break;
      tick();
    end
    check(name, irq_req, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [4:0]  addr_tbl [8];
    logic [4:0]  a;
    logic [31:0] d;
    int          op;

    addr_tbl = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};
    cpurst_n = 1'b0;
    bus_wr = 1'b0; bus_rd = 1'b0; bus_addr = 5'd0; bus_wdata = 32'd0;
    ext_irq = 1'b0; mstatus = 32'd0; mie = 32'd0; irq_ack = 1'b0;

    repeat (3) tick();
    check("rst_irq_req", irq_req, 1'b0);
    check("rst_mip", {mip_msip, mip_mtip, mip_meip}, 3'b000);
    check("rst_rvalid", bus_rvalid, 1'b0);
    cpurst_n = 1'b1;
    chk_en   = 1'b1;

    bus_read(5'h08);
    bus_read(5'h0C);
    bus_read(5'h10);
    bus_read(5'h14);
    bus_read(5'h04);
    bus_read(5'h1C);
    check("rst_idle_req", irq_req, 1'b0);

    // Software interrupt and HOLD length.
    mstatus = 32'h8;
    mie     = 32'h800;
    cause_q.push_back(3'b010);
    bus_write(5'h00, 32'h1);
    check("msip_set", mip_msip, 1'b1);
    check("msip_req_delay", irq_req, 1'b0);
    tick();
    check("ms_req", {irq_req, irq_me, irq_ms, irq_mt}, 4'b1010);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("ack_hold", irq_req, 1'b0);
    cause_q.push_back(3'b010);
    tick();
    check("hold_idle", irq_req, 1'b0);
    tick();
    check("rereq", irq_req, 1'b1);

    // Withdraw.
    mstatus = 32'h0;
    tick();
    check("withdraw", irq_req, 1'b0);

    // Ack and withdraw together: ack wins, so HOLD delays the next request.
    mstatus = 32'h8;
    cause_q.push_back(3'b010);
    tick();
    check("req_again", irq_req, 1'b1);
    mstatus = 32'h0;
    irq_ack = 1'b1;
    tick();
    check("ack_withdraw_drop", irq_req, 1'b0);
    mstatus = 32'h8;
    irq_ack = 1'b0;
    tick();
    check("ack_won_hold", irq_req, 1'b0);
    cause_q.push_back(3'b010);
    tick();
    check("req_after_hold", irq_req, 1'b1);

    // Higher-priority source arriving in REQ keeps the latched cause.
    mie     = 32'h888;
    ext_irq = 1'b1;
    tick();
    check("meip_sync1", mip_meip, 1'b0);
    tick();
    tick();
    check("meip_sync3", mip_meip, 1'b1);
    tick();
    tick();
    check("cause_stable", {irq_req, irq_me, irq_ms, irq_mt}, 4'b1010);
    irq_ack = 1'b1;
    cause_q.push_back(3'b100);
    tick();
    irq_ack = 1'b0;
    tick();
    tick();
    check("me_prio", {irq_req, irq_me, irq_ms, irq_mt}, 4'b1100);
    irq_ack = 1'b1;
    mstatus = 32'h0;
    tick();
    irq_ack = 1'b0;
    ext_irq = 1'b0;
    bus_write(5'h00, 32'h0);
    repeat (6) tick();
    check("me_cleared", {irq_req, mip_meip}, 2'b00);

    // Timer interrupt.
    mie = 32'h80;
    bus_write(5'h0C, 32'h0);
    bus_write(5'h08, 32'h20);
    bus_write(5'h14, 32'h0);
    bus_write(5'h10, 32'h0);
    cause_q.push_back(3'b001);
    mstatus = 32'h8;
    wait_req(32'h20 * P + 10, "mt_req_timeout");
    check("mt_cause", {irq_me, irq_ms, irq_mt}, 3'b001);
    check("mt_mtime_reached", (m_mtime >= 64'h20), 1'b1);
    irq_ack = 1'b1;
    mstatus = 32'h0;
    tick();
    irq_ack = 1'b0;
    bus_write(5'h0C, 32'hFFFF_FFFF);
    mie = 32'h0;

    // Carry from lo into hi.
    bus_write(5'h14, 32'h0);
    bus_write(5'h10, 32'hFFFF_FFFF);
    repeat (P) tick();
    bus_read(5'h14);
    bus_read(5'h10);

    // Randomized register traffic, including same-cycle read/write and unmapped offsets.
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 3);
      a  = addr_tbl[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) a = 5'($urandom_range(0, 31));
      d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
      if (op == 3) tick();
      else bus_op(op != 1, op != 0, a, d);
    end

    // Reset in the middle of a request.
    mie = 32'h800;
    bus_write(5'h00, 32'h1);
    cause_q.push_back(3'b010);
    mstatus = 32'h8;
    wait_req(5, "pre_reset_req_timeout");
    #2 cpurst_n = 1'b0;
    #1;
    check("async_reset_req", {irq_req, irq_ms, mip_msip}, 3'b000);
    tick();
    cpurst_n = 1'b1;
    bus_read(5'h00);
    bus_read(5'h08);
    repeat (3) tick();
    check("post_reset_req", irq_req, 1'b0);

    check("rd_queue_empty", rd_q.size(), 0);
    check("cause_queue_empty", cause_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_timer_gen.md
Name: irq_timer_gen

Overview:
- Machine-level interrupt source block feeding the write-back/CSR trap logic.
- Holds the memory-mapped software-interrupt bit (msip), a 64-bit mtime counter and a 64-bit mtimecmp register, plus a 2-flop synchroniser for the external interrupt line.
- Qualifies pending sources with mstatus.MIE and mie.
- Issues a one-hot interrupt request to the pipeline with a req/ack handshake; write-back returns ack when it takes the trap.

Parameters:
PRESCALE, 1, mtime increments once every PRESCALE clk cycles; legal range 1..65535.
MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp, so no timer interrupt fires out of reset.

Ports:
clk  in  1  core clock
cpurst_n  in  1  asynchronous active-low reset
bus_wr  in  1  register write strobe, single cycle
bus_rd  in  1  register read strobe, single cycle
bus_addr  in  5  byte offset: 0x00 msip, 0x08 mtimecmp lo, 0x0C mtimecmp hi, 0x10 mtime lo, 0x14 mtime hi
bus_wdata  in  32  write data
bus_rdata  out  32  read data, registered
bus_rvalid  out  1  read data valid, one cycle after bus_rd
ext_irq  in  1  asynchronous external interrupt level
mstatus  in  32  current mstatus; bit 3 = MIE
mie  in  32  current mie; bit 11 = MSIE, bit 7 = MTIE, bit 3 = MEIE
mip_msip / mip_mtip / mip_meip  out  1 each  pending levels, registered
irq_req  out  1  interrupt request to write-back
irq_ms / irq_mt / irq_me  out  1 each  one-hot cause, valid while irq_req is high
irq_ack  in  1  write-back took the trap this cycle

Behaviour:
- Reset (async assert, sync deassert handled upstream): msip=0, mtime=0, mtimecmp=MTIMECMP_RST, prescale counter=0, sync flops=0, all outputs 0, FSM=IDLE.
- Register writes take effect on the next clk edge.
  - msip takes wdata[0]; msip reads back as {31'b0, msip}.
  - Unmapped offsets: writes are ignored; reads return 0.
- Register reads: bus_rdata and bus_rvalid are valid one cycle after bus_rd. Read and write in the same cycle returns the old value.
- mtime:
  - The prescale counter counts 0..PRESCALE-1. Its wrap produces a tick; mtime += 1 (64-bit, carry from lo into hi, wraps to 0 after all-ones).
  - A bus write to mtime lo or hi overrides the increment in that cycle; the other half is held unchanged.
- Pending levels:
  - mip_mtip <= (mtime >= mtimecmp), unsigned 64-bit compare on the current register values.
  - mip_meip <= second synchroniser stage, so ext_irq reaches mip_meip with a latency of 2–3 clk.
  - mip_msip = msip.
- Qualification:
  - en_me = mip_meip & mie[3]; en_ms = mip_msip & mie[11]; en_mt = mip_mtip & mie[7].
  - take = mstatus[3] & (en_me | en_ms | en_mt).
  - Priority: me > ms > mt.
- FSM states: IDLE, REQ, HOLD.
  - IDLE: if take, go to REQ next cycle and latch the one-hot cause by priority.
  - REQ: irq_req=1 and the cause is held stable.
    - irq_ack: go to HOLD.
    - Else if take=0 (the source cleared or was disabled by software): withdraw, go to IDLE, irq_req drops next cycle.
    - ack and withdraw in the same cycle: ack wins.
    - A higher-priority source appearing in REQ does not change the latched cause.
  - HOLD: lasts exactly 1 cycle, giving the CSR file time to clear mstatus.MIE; then go to IDLE.
  - irq_ack outside REQ is ignored.
- Reset mid-request: irq_req drops immediately (async); the pending trap is lost.

Decomposition:
- Shared package holds:
  - register offset constants (MSIP_OFS, MTIMECMP_LO/HI_OFS, MTIME_LO/HI_OFS);
  - mie/mip bit positions (MSI=11, MTI=7, MEI=3) and MSTATUS_MIE=3;
  - FSM state encoding.
- One natural sub-module: mtime_counter, holding the prescaler, the 64-bit mtime and the write-override logic.
- The synchroniser, compare, FSM and bus decode stay in the top level.

Test Plan:
- Reset: release cpurst_n, read 0x08 and 0x0C → 0xFFFFFFFF each; read 0x10 → value small (counting), irq_req=0, all mip_* = 0.
- Software interrupt: mstatus=0x8, mie=0x800, write 0x00=1 → mip_msip=1 next cycle, irq_req=1 and irq_ms=1 one cycle later; pulse irq_ack → HOLD then IDLE.
- Timer: PRESCALE=1, write mtimecmp hi=0, lo=0x20, then mtime hi=0, lo=0 → mip_mtip rises 0x20 ticks after the mtime write (+1 cycle register); with mie=0x80 and mstatus=0x8, irq_mt asserts.
- Priority and stability: msip=1, then raise ext_irq with mie=0x888; with ext_irq raised in IDLE before take → irq_me; with ext_irq raised after REQ latched irq_ms → irq_ms stays until ack.
- Withdraw vs ack: in REQ, drop mstatus to 0 → irq_req=0 next cycle; repeat with irq_ack in the same cycle → HOLD, ack honoured.
- Carry and override: write mtime lo=0xFFFFFFFF, hi=0 → next tick reads hi=1, lo=0; a write on a tick cycle keeps the written value with no increment.
